// File: rtl/alarm_timing_pkg.sv
// Shared definitions for the alarm timing blocks.
// - timer_state_e : countdown FSM state encoding
// - *_S constants : factory default time values in seconds
package alarm_timing_pkg;

    localparam int unsigned DEFAULT_VALUE_W = 4;

    // Factory default times (seconds)
    localparam logic [DEFAULT_VALUE_W-1:0] ARM_S       = 4'd6;
    localparam logic [DEFAULT_VALUE_W-1:0] DRIVER_S    = 4'd8;
    localparam logic [DEFAULT_VALUE_W-1:0] PASSENGER_S = 4'd15;
    localparam logic [DEFAULT_VALUE_W-1:0] ALARM_ON_S  = 4'd10;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StCount  = 2'b01,
        StExpire = 2'b10
    } timer_state_e;

endpackage

// File: rtl/param_countdown.sv
// Countdown FSM with its remaining-seconds counter.
// Ports:
//   clk_i          clock
//   rst_ni         asynchronous active-low reset
//   start_i        load load_value_i and (re)start the countdown
//   load_value_i   value to load on start
//   tick_i         one-per-second decrement strobe
//   remaining_o    current count
//   busy_o         countdown in progress
//   expired_o      one-cycle pulse when the countdown ends
module param_countdown
    import alarm_timing_pkg::*;
#(
    parameter int unsigned VALUE_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [VALUE_W-1:0] load_value_i,
    input  logic               tick_i,
    output logic [VALUE_W-1:0] remaining_o,
    output logic               busy_o,
    output logic               expired_o
);

    timer_state_e       state_q, state_d;
    logic [VALUE_W-1:0] remaining_q, remaining_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        // Start wins over a tick in the same cycle, in every state.
        if (start_i) begin
            remaining_d = load_value_i;
            state_d     = (load_value_i != '0) ? StCount : StExpire;
        end else begin
            unique case (state_q)
                StIdle: ;
                StCount: begin
                    if (tick_i) begin
                        if (remaining_q > VALUE_W'(1)) begin
                            remaining_d = remaining_q - VALUE_W'(1);
                        end else begin
                            remaining_d = '0;
                            state_d     = StExpire;
                        end
                    end
                end
                StExpire: state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    assign remaining_o = remaining_q;
    assign busy_o      = (state_q == StCount);
    assign expired_o   = (state_q == StExpire);

endmodule

// File: rtl/param_timer.sv
// Programmable time-parameter store with a one-second countdown timer.
// Ports:
//   clk            clock
//   reset_n        asynchronous active-low reset
//   reprogram      write prog_value into entry prog_sel
//   prog_sel       entry to write (out-of-range writes are dropped)
//   prog_value     value to write
//   interval       entry used for the value lookup and timer load
//   start_timer    load entry[interval] into the countdown
//   one_hz_enable  one-per-second tick
//   value          registered entry[interval]
//   remaining      countdown count
//   busy           countdown in progress
//   expired        one-cycle pulse at countdown end
module param_timer
    import alarm_timing_pkg::*;
#(
    parameter int unsigned                     NUM_PARAMS = 4,
    parameter int unsigned                     VALUE_W    = 4,
    parameter logic [NUM_PARAMS*VALUE_W-1:0]   DEFAULTS   =
        {ALARM_ON_S, PASSENGER_S, DRIVER_S, ARM_S},
    localparam int unsigned                    SEL_W      =
        (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               reprogram,
    input  logic [SEL_W-1:0]   prog_sel,
    input  logic [VALUE_W-1:0] prog_value,
    input  logic [SEL_W-1:0]   interval,
    input  logic               start_timer,
    input  logic               one_hz_enable,
    output logic [VALUE_W-1:0] value,
    output logic [VALUE_W-1:0] remaining,
    output logic               busy,
    output logic               expired
);

    logic [VALUE_W-1:0] params_q [NUM_PARAMS];
    logic [VALUE_W-1:0] lookup;
    logic [VALUE_W-1:0] value_q;

    // Parameter store. An index that matches no entry writes nothing.
    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_param
        logic [VALUE_W-1:0] param_d;

        always_comb begin
            param_d = params_q[g];
            if (reprogram && (prog_sel == SEL_W'(g))) begin
                param_d = prog_value;
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                params_q[g] <= DEFAULTS[g*VALUE_W +: VALUE_W];
            end else begin
                params_q[g] <= param_d;
            end
        end
    end

    // Reads the stored (pre-write) contents, so a same-cycle write is not seen
    // by either the lookup register or the timer load.
    always_comb begin
        lookup = '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            if (interval == SEL_W'(i)) begin
                lookup = params_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= '0;
        end else begin
            value_q <= lookup;
        end
    end

    assign value = value_q;

    param_countdown #(
        .VALUE_W (VALUE_W)
    ) u_countdown (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .start_i      (start_timer),
        .load_value_i (lookup),
        .tick_i       (one_hz_enable),
        .remaining_o  (remaining),
        .busy_o       (busy),
        .expired_o    (expired)
    );

endmodule

// File: tb/tb_param_timer.sv
// Directed self-checking bench for param_timer (default configuration).
module tb_param_timer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       reprogram;
    logic [1:0] prog_sel;
    logic [3:0] prog_value;
    logic [1:0] interval;
    logic       start_timer;
    logic       one_hz_enable;
    logic [3:0] value;
    logic [3:0] remaining;
    logic       busy;
    logic       expired;

    int n_cmp = 0;
    int n_bad = 0;

    param_timer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .reprogram     (reprogram),
        .prog_sel      (prog_sel),
        .prog_value    (prog_value),
        .interval      (interval),
        .start_timer   (start_timer),
        .one_hz_enable (one_hz_enable),
        .value         (value),
        .remaining     (remaining),
        .busy          (busy),
        .expired       (expired)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int         exp_default [4] = '{6, 8, 15, 10};
    int         k;

    initial begin
        reset_n       = 1'b1;
        reprogram     = 1'b0;
        prog_sel      = '0;
        prog_value    = '0;
        interval      = '0;
        start_timer   = 1'b0;
        one_hz_enable = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        check_eq("rst_value", 32'(value), 0);
        check_eq("rst_remaining", 32'(remaining), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_expired", 32'(expired), 0);
        #19 reset_n = 1'b1;

        // Default lookups, 1-cycle latency
        for (int i = 0; i < 4; i++) begin
            interval = 2'(i);
            step();
            check_eq($sformatf("default_val%0d", i), 32'(value), 32'(exp_default[i]));
        end

        // Write entry 2 = 3 while looking it up: old value first, new one a cycle later
        reprogram = 1'b1; prog_sel = 2'd2; prog_value = 4'd3; interval = 2'd2;
        step();
        reprogram = 1'b0;
        check_eq("val_prewrite", 32'(value), 15);
        step();
        check_eq("val_postwrite", 32'(value), 3);
        interval = 2'd1;
        step();
        check_eq("val_sel1_kept", 32'(value), 8);

        // Full countdown from 6, ticks every 5 cycles
        interval = 2'd0; start_timer = 1'b1;
        step();
        start_timer = 1'b0;
        check_eq("cnt_load_rem", 32'(remaining), 6);
        check_eq("cnt_load_busy", 32'(busy), 1);
        for (k = 1; k <= 6; k++) begin
            repeat (4) step();
            if (k == 1) check_eq("cnt_hold_rem", 32'(remaining), 6);
            one_hz_enable = 1'b1;
            step();
            one_hz_enable = 1'b0;
            if (k < 6) begin
                check_eq($sformatf("cnt_rem_t%0d", k), 32'(remaining), 32'(6 - k));
                check_eq($sformatf("cnt_busy_t%0d", k), 32'(busy), 1);
                check_eq($sformatf("cnt_exp_t%0d", k), 32'(expired), 0);
            end
        end
        check_eq("end_rem", 32'(remaining), 0);
        check_eq("end_expired", 32'(expired), 1);
        check_eq("end_busy", 32'(busy), 0);
        step();
        check_eq("end_expired_off", 32'(expired), 0);
        check_eq("end_rem_hold", 32'(remaining), 0);
        // Tick in IDLE does nothing
        one_hz_enable = 1'b1;
        step();
        one_hz_enable = 1'b0;
        check_eq("idle_tick_rem", 32'(remaining), 0);
        check_eq("idle_tick_busy", 32'(busy), 0);

        // Entry 3 = 0, then start on 3 while writing 9 to it: pre-write 0 is loaded
        reprogram = 1'b1; prog_sel = 2'd3; prog_value = 4'd0;
        step();
        prog_value = 4'd9; interval = 2'd3; start_timer = 1'b1;
        step();
        reprogram = 1'b0; start_timer = 1'b0;
        check_eq("zero_busy", 32'(busy), 0);
        check_eq("zero_expired", 32'(expired), 1);
        check_eq("zero_rem", 32'(remaining), 0);
        step();
        check_eq("zero_expired_off", 32'(expired), 0);
        start_timer = 1'b1;
        step();
        start_timer = 1'b0;
        check_eq("postwrite_load", 32'(remaining), 9);

        // Restart from remaining=4 with a tick in the same cycle
        interval = 2'd0; start_timer = 1'b1;
        step();
        start_timer = 1'b0;
        one_hz_enable = 1'b1;
        step();
        step();
        check_eq("restart_pre_rem", 32'(remaining), 4);
        interval = 2'd1; start_timer = 1'b1;
        step();
        start_timer = 1'b0; one_hz_enable = 1'b0;
        check_eq("restart_rem", 32'(remaining), 8);
        check_eq("restart_busy", 32'(busy), 1);
        // Reprogramming mid-count leaves remaining alone
        reprogram = 1'b1; prog_sel = 2'd1; prog_value = 4'd2;
        step();
        reprogram = 1'b0;
        check_eq("reprog_count_rem", 32'(remaining), 8);
        one_hz_enable = 1'b1;
        step();
        one_hz_enable = 1'b0;
        check_eq("reprog_tick_rem", 32'(remaining), 7);

        // Asynchronous reset mid-count
        interval = 2'd2;
        reset_n = 1'b0;
        #1;
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_rem", 32'(remaining), 0);
        check_eq("arst_expired", 32'(expired), 0);
        check_eq("arst_value", 32'(value), 0);
        #12;
        check_eq("arst_hold_expired", 32'(expired), 0);
        #8 reset_n = 1'b1;
        step();
        check_eq("arst_exp_after", 32'(expired), 0);
        check_eq("arst_default2", 32'(value), 15);
        interval = 2'd1;
        step();
        check_eq("arst_default1", 32'(value), 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
